// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
// FSM encoding is fixed: IDLE=0, LOAD=1, WAIT=2, DONE=3.
package mult_share_arbiter_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_OPW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping at N.
// Reusable by any shared-resource arbiter.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);

  localparam logic [PW:0] NV = (PW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  enc;
  logic [PW:0]    sum;

  // Rotate so ptr becomes bit 0, then the lowest set bit is the winner.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N];

  always_comb begin
    enc = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) enc = PW'(j);
    end
  end

  assign valid = |req;
  assign sum   = {1'b0, ptr} + {1'b0, enc};
  assign idx   = (sum >= NV) ? PW'(sum - NV) : sum[PW-1:0];

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential multiplier (ld / rdy handshake) among NREQ requesters, round-robin.
// Optional watchdog abort: define MULT_SHARE_ARBITER_WATCHDOG_EN.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int OPW     = DEF_OPW,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*OPW-1:0] a_in,
  input  logic [NREQ*OPW-1:0] b_in,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [2*OPW-1:0]    res,
  output logic                mult_ld,
  output logic [OPW-1:0]      mult_a,
  output logic [OPW-1:0]      mult_b,
  input  logic                mult_rdy,
  input  logic [2*OPW-1:0]    mult_res,
  output logic                err
);

  localparam int          PW = $clog2(NREQ);
  localparam logic [PW:0] NV = (PW+1)'(NREQ);

  state_t        state, state_nx;
  logic [PW-1:0] ptr, win, pick_idx, win_next;
  logic [PW:0]   win_inc;
  logic          pick_valid, guard, take, abort;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign win_inc  = {1'b0, win} + (PW+1)'(1);
  assign win_next = (win_inc == NV) ? '0 : win_inc[PW-1:0];

  // The guard cycle hides a ready left over from the previous operation.
  assign take = (state == ST_WAIT) && !guard && mult_rdy;

`ifdef MULT_SHARE_ARBITER_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  assign abort = (state == ST_WAIT) && !take && (wd_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= abort;
      if (state == ST_LOAD) wd_cnt <= '0;
      else if (state == ST_WAIT) wd_cnt <= wd_cnt + TW'(1);
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_valid) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (take)       state_nx = ST_DONE;
        else if (abort) state_nx = ST_IDLE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mult_ld = (state == ST_LOAD);
    done    = (state == ST_DONE) ? gnt : '0;
  end

  // Operands and grant are captured once; nothing here looks at req after IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      win    <= '0;
      gnt    <= '0;
      res    <= '0;
      mult_a <= '0;
      mult_b <= '0;
      guard  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            win    <= pick_idx;
            gnt    <= NREQ'(1) << pick_idx;
            mult_a <= a_in[pick_idx*OPW +: OPW];
            mult_b <= b_in[pick_idx*OPW +: OPW];
          end
        end
        ST_LOAD: guard <= 1'b1;
        ST_WAIT: begin
          guard <= 1'b0;
          if (take) begin
            res <= mult_res;
          end else if (abort) begin
            gnt <= '0;
            ptr <= win_next;
          end
        end
        ST_DONE: begin
          gnt <= '0;
          ptr <= win_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier and round-robin model.
// Watchdog scenario runs only when MULT_SHARE_ARBITER_WATCHDOG_EN is defined.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] a_in, b_in;
  logic [3:0]  gnt, done;
  logic [15:0] res;
  logic        mult_ld;
  logic [7:0]  mult_a, mult_b;
  logic        mult_rdy = 1'b0;
  logic [15:0] mult_res = 16'h0;
  logic        err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ref_ptr = 0;
  logic [15:0] ref_res = 16'h0;
  int          lat_cfg = 0;
  bit          stale_cfg = 1'b0;

  int          m_cnt = 0;
  bit          m_busy = 1'b0;
  logic [15:0] m_prod = 16'h0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(4), .OPW(8), .TIMEOUT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .gnt      (gnt),
    .done     (done),
    .res      (res),
    .mult_ld  (mult_ld),
    .mult_a   (mult_a),
    .mult_b   (mult_b),
    .mult_rdy (mult_rdy),
    .mult_res (mult_res),
    .err      (err)
  );

  // Sequential multiplier: ready appears lat_cfg cycles after the first real wait cycle.
  // Ready stays high after a result; a stale multiplier keeps it high across the next load.
  always @(negedge clk) begin
    if (reset) begin
      m_busy   = 1'b0;
      mult_rdy = 1'b0;
    end else if (mult_ld) begin
      m_busy = 1'b1;
      m_cnt  = 1 + lat_cfg;
      m_prod = 16'(mult_a) * 16'(mult_b);
      if (!stale_cfg) mult_rdy = 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        mult_rdy = 1'b1;
        mult_res = m_prod;
        m_busy   = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  end

  function automatic int ref_winner(logic [3:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(ref_ptr + i) % N]) return (ref_ptr + i) % N;
    end
    return 0;
  endfunction

  function automatic logic [3:0] oh(int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  // One full operation starting in an IDLE cycle with req/a_in/b_in already driven.
  task automatic do_op(input string name, input int lat, input int chg_k,
                       input logic [3:0] req_new, input logic [31:0] a_new,
                       input logic [31:0] b_new, output int w_out);
    int w, done_at, ld_cnt;
    logic [7:0] ea, eb;
    logic [15:0] p;
    logic [3:0] done_seen;
    bit gnt_bad, res_bad;
    w  = ref_winner(req);
    ea = a_in[w*8 +: 8];
    eb = b_in[w*8 +: 8];
    p  = 16'(ea) * 16'(eb);
    lat_cfg = lat;
    done_at = -1; ld_cnt = 0; done_seen = 4'b0; gnt_bad = 1'b0; res_bad = 1'b0;
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (mult_ld !== 1'b1 || mult_a !== ea || mult_b !== eb) begin
          n_errors++;
          $display("[TB] FAIL %s load: ld=%b a=%h b=%h, required ld=1 a=%h b=%h",
                   name, mult_ld, mult_a, mult_b, ea, eb);
        end
      end
      if (mult_ld === 1'b1) ld_cnt++;
      if (gnt !== oh(w)) gnt_bad = 1'b1;
      if (done !== 4'b0) begin
        done_at = k;
        done_seen = done;
      end else if (res !== ref_res) begin
        res_bad = 1'b1;
      end
      if (k == chg_k) begin
        req = req_new; a_in = a_new; b_in = b_new;
      end
    end
    n_checks++;
    if (done_at != 4 + lat) begin
      n_errors++;
      $display("[TB] FAIL %s latency: done at cycle %0d, required %0d", name, done_at, 4 + lat);
    end
    n_checks++;
    if (done_seen !== oh(w)) begin
      n_errors++;
      $display("[TB] FAIL %s done: got %b, required %b", name, done_seen, oh(w));
    end
    n_checks++;
    if (res !== p) begin
      n_errors++;
      $display("[TB] FAIL %s res: got %h, required %h", name, res, p);
    end
    n_checks++;
    if (gnt_bad || ld_cnt != 1 || res_bad) begin
      n_errors++;
      $display("[TB] FAIL %s during op: gnt_bad=%0d ld_pulses=%0d res_moved=%0d, required 0 1 0",
               name, gnt_bad, ld_cnt, res_bad);
    end
    ref_res = p;
    ref_ptr = (w + 1) % N;
    w_out   = w;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || mult_ld !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL %s idle gap: gnt=%b done=%b ld=%b, required all 0", name, gnt, done, mult_ld);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || res !== 16'h0 || mult_ld !== 1'b0 ||
        mult_a !== 8'h0 || mult_b !== 8'h0 || err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset: gnt=%b done=%b res=%h ld=%b a=%h b=%h err=%b, required all 0",
               gnt, done, res, mult_ld, mult_a, mult_b, err);
    end
    reset = 1'b0;
    @(negedge clk);
    ref_ptr = 0; ref_res = 16'h0;
  endtask

  task automatic test_round_robin();
    int w;
    logic [15:0] exp_res [4] = '{16'h0001, 16'h0004, 16'h0009, 16'h0010};
    req = 4'b1111; a_in = 32'h04030201; b_in = 32'h04030201;
    for (int i = 0; i < 4; i++) begin
      do_op("rr", i % 2, 1, 4'b1111, a_in, b_in, w);
      n_checks++;
      if (w != i || res !== exp_res[i]) begin
        n_errors++;
        $display("[TB] FAIL rr order: slot %0d winner %0d res %h, required %0d %h", i, w, res, i, exp_res[i]);
      end
    end
    do_op("rr_wrap", 0, 1, 4'b0000, a_in, b_in, w);
    n_checks++;
    if (w != 0) begin
      n_errors++;
      $display("[TB] FAIL rr wrap: model winner %0d, required 0", w);
    end
  endtask

  task automatic test_single();
    int w;
    req = 4'b0001; a_in = 32'h00000012; b_in = 32'h00000034;
    do_op("single", 1, 1, 4'b0000, a_in, b_in, w);
    n_checks++;
    if (res !== 16'h03A8) begin
      n_errors++;
      $display("[TB] FAIL single value: res=%h, required 03a8", res);
    end
  endtask

  task automatic test_stale_ready();
    int w;
    stale_cfg = 1'b1;
    req = 4'b1000; a_in = 32'h05000000; b_in = 32'h07000000;
    do_op("stale", 0, 1, 4'b0000, a_in, b_in, w);
    stale_cfg = 1'b0;
    n_checks++;
    if (res !== 16'h0023) begin
      n_errors++;
      $display("[TB] FAIL stale value: res=%h, required 0023", res);
    end
  endtask

  task automatic test_operand_change();
    int w;
    req = 4'b0010; a_in = 32'h0000FF00; b_in = 32'h0000FF00;
    do_op("opchg", 2, 2, 4'b0000, 32'h0, b_in, w);
    n_checks++;
    if (res !== 16'hFE01 || w != 1) begin
      n_errors++;
      $display("[TB] FAIL opchg value: res=%h winner=%0d, required fe01 1", res, w);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    bit done_bad;
    req = 4'b0100; a_in = 32'h00090000; b_in = 32'h00090000;
    lat_cfg = 5;
    repeat (2) @(negedge clk);
    reset = 1'b1; req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || res !== 16'h0 || mult_ld !== 1'b0 ||
        mult_a !== 8'h0 || mult_b !== 8'h0 || err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset mid: gnt=%b done=%b res=%h ld=%b a=%h b=%h err=%b, required all 0",
               gnt, done, res, mult_ld, mult_a, mult_b, err);
    end
    done_bad = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done !== 4'b0 || gnt !== 4'b0) done_bad = 1'b1;
    end
    n_checks++;
    if (done_bad) begin
      n_errors++;
      $display("[TB] FAIL reset abort: activity after reset, required none");
    end
    ref_ptr = 0; ref_res = 16'h0;
    req = 4'b0110; a_in = 32'h00030200; b_in = 32'h00050600;
    do_op("post_reset_ptr", 0, 1, 4'b0000, a_in, b_in, w);
    n_checks++;
    if (w != 1) begin
      n_errors++;
      $display("[TB] FAIL post reset ptr: model winner %0d, required 1", w);
    end
    req = 4'b0100; a_in = 32'h00110000; b_in = 32'h00030000;
    do_op("fresh_req2", 1, 1, 4'b0000, a_in, b_in, w);
  endtask

  task automatic test_idle();
    bit bad;
    bad = 1'b0;
    req = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (gnt !== 4'b0 || mult_ld !== 1'b0 || err !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("[TB] FAIL idle: activity without request, required none");
    end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 24; i++) begin
      req  = 4'($urandom_range(1, 15));
      a_in = $urandom; b_in = $urandom;
      do_op("random", $urandom_range(0, 3), 1, 4'($urandom_range(0, 15)), $urandom, $urandom, w);
    end
    req = 4'b0000;
  endtask

`ifdef MULT_SHARE_ARBITER_WATCHDOG_EN
  task automatic test_watchdog();
    int w, w2, err_at, err_cnt;
    bit done_bad;
    req = 4'b0001; a_in = 32'h00000033; b_in = 32'h00000044;
    w = ref_winner(req);
    lat_cfg = 1000;
    err_at = -1; err_cnt = 0; done_bad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req = 4'b0000;
      if (err === 1'b1) begin
        err_cnt++;
        if (err_at < 0) err_at = k;
      end
      if (done !== 4'b0) done_bad = 1'b1;
    end
    n_checks++;
    if (err_at != 10 || err_cnt != 1 || done_bad || res !== ref_res) begin
      n_errors++;
      $display("[TB] FAIL watchdog: err at %0d x%0d done_seen=%0d res=%h, required 10 x1 0 %h",
               err_at, err_cnt, done_bad, res, ref_res);
    end
    ref_ptr = (w + 1) % N;
    req = 4'b1111; a_in = 32'h02020202; b_in = 32'h03030303;
    do_op("after_watchdog", 0, 1, 4'b0000, a_in, b_in, w2);
    n_checks++;
    if (w2 != (w + 1) % N) begin
      n_errors++;
      $display("[TB] FAIL watchdog next: model winner %0d, required %0d", w2, (w + 1) % N);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stale_ready();
    test_operand_change();
    test_reset_mid();
    test_idle();
    test_random();
`ifdef MULT_SHARE_ARBITER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
